bmp_capture_ctrl: RTL
=====================

Name: bmp_capture_ctrl

Overview:
Sequences capture of one video frame from the display-timing path (vsync/hsync/de plus 24-bit RGB pixel) into a byte-addressed BMP image buffer. Reorders the frame into BMP layout: bottom-up rows, BGR byte order, rows padded to a 4-byte stride, pixel array after a fixed 54-byte header. Sits between disp_sync_gen/pixel source and the frame-buffer memory that the bench dumps as a .bmp file.

Parameters:
HRES, 320, active pixels per line
VRES, 240, active lines per frame
HDR_BYTES, 54, byte offset of pixel array (file header 14 + info header 40)
ADDR_W, 18, byte-address width; must hold HDR_BYTES + VRES*STRIDE
(derived localparam) STRIDE = ((HRES*3+3)/4)*4, padded row size in bytes

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_arm  in  1  one-cycle pulse: capture the next complete frame
i_abort  in  1  one-cycle pulse: drop current capture, return to IDLE
i_vsync  in  1  frame sync, active high
i_hsync  in  1  line sync, active high (monitored only)
i_de  in  1  active-pixel enable
i_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}
o_wr_en  out  1  write strobe to image buffer
o_wr_addr  out  ADDR_W  byte address of pixel's first (B) byte
o_wr_data  out  24  {R,G,B}; memory stores B at addr, G at +1, R at +2
o_busy  out  1  high in ARMED or CAPTURE
o_done  out  1  one-cycle pulse, frame captured without error
o_err  out  1  sticky geometry error; cleared by i_arm

Behaviour:
- Reset: every output 0; state IDLE; counters and row base cleared. Reset mid-capture aborts with no o_done.
- States: IDLE -> (i_arm) ARMED -> (vsync rising edge) CAPTURE -> (next vsync rising edge) DONE -> IDLE after 1 cycle.
- i_arm in IDLE: clears o_err, enters ARMED. i_arm outside IDLE is ignored.
- i_abort in ARMED/CAPTURE: IDLE next cycle; no o_done; o_err unchanged. i_abort wins over a same-cycle vsync edge.
- Edge detection: i_vsync and i_de are registered once; edges are taken against the registered copy.
- CAPTURE, on entry: x=0, y=0, row_base = HDR_BYTES + (VRES-1)*STRIDE, pix_addr = row_base.
- Each cycle with i_de=1 and x<HRES:
  - next cycle: o_wr_en=1, o_wr_addr=pix_addr, o_wr_data=i_data (latency 1, registered);
  - pix_addr += 3; x++.
- i_de=1 with x>=HRES: no write, o_err set.
- i_de falling edge:
  - if x!=HRES, set o_err;
  - y++, x=0, row_base -= STRIDE, pix_addr = new row_base;
  - if y was already VRES, set o_err and suppress writes until frame end.
- No multiplier: addresses come from add/subtract only.
- Pad bytes (STRIDE - HRES*3 per row) are never written.
- Frame end (vsync rising edge in CAPTURE):
  - if y!=VRES, or a line is still open (de high at the edge), set o_err;
  - enter DONE; o_done=1 for that single cycle only if o_err=0.
- o_wr_en is never asserted outside CAPTURE, except the 1-cycle drain of the last pixel.
- i_hsync is not used for counting. An hsync pulse while de=1 sets o_err.

Decomposition:
- Shared package bmp_pkg holds:
  - state enum {IDLE, ARMED, CAPTURE, DONE};
  - BMP_HDR_BYTES=54 and BMP_BYTES_PER_PIX=3;
  - function bmp_stride(hres);
  - function bmp_file_size(hres, vres), for the header writer and the bench.
- One sub-module, bmp_addr_gen, holds row_base/pix_addr and the x/y counters with load, next_pix and next_row controls. The FSM and error logic stay in the top module.

Test Plan:
- HRES=4, VRES=2, arm then one clean frame -> 8 writes at addresses 66,69,72,75 (top line), then 54,57,60,63; o_done pulses once; o_err=0.
- HRES=5, VRES=2 -> STRIDE=16; top line writes at 70,73,76,79,82; bottom line at 54..66 step 3; bytes 69 and 85 untouched.
- Line with only 3 de cycles (HRES=4) -> o_err=1 at de fall, no o_done, FSM reaches IDLE at next vsync; a following i_arm clears o_err.
- i_abort mid-line after 2 pixels -> o_busy=0 next cycle, no further o_wr_en, no o_done; a re-armed frame then captures cleanly.
- i_arm during active video (vsync low) -> no writes until the next vsync rising edge; the first write goes to row_base of the bottom-up top line.
- i_rst asserted mid-CAPTURE -> all outputs 0 the next cycle; state IDLE; i_data=24'hFF0000 is presented as {R,G,B}, so memory bytes at addr..addr+2 read 00,00,FF.

Source files
------------

// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP frame-capture path: FSM encodings, header
// geometry and stride/file-size helpers used by RTL and bench alike.
package bmp_pkg;

  localparam int unsigned BMP_HDR_BYTES     = 54;
  localparam int unsigned BMP_BYTES_PER_PIX = 3;

  typedef logic [1:0] bmp_state_t;

  localparam bmp_state_t StIdle    = 2'd0;
  localparam bmp_state_t StArmed   = 2'd1;
  localparam bmp_state_t StCapture = 2'd2;
  localparam bmp_state_t StDone    = 2'd3;

  // BMP rows are padded up to a multiple of 4 bytes.
  function automatic int unsigned bmp_stride(input int unsigned hres);
    return ((hres * BMP_BYTES_PER_PIX + 3) / 4) * 4;
  endfunction

  function automatic int unsigned bmp_file_size(input int unsigned hres,
                                                input int unsigned vres);
    return BMP_HDR_BYTES + vres * bmp_stride(hres);
  endfunction

endpackage

// File: rtl/bmp_capture_ctrl_if.sv
// Video-in / image-buffer-write bundle between a pixel source, the capture
// controller and the frame-buffer memory.
interface bmp_capture_ctrl_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              vsync;
  logic              hsync;
  logic              de;
  logic [23:0]       data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;

  modport master (
    output vsync, hsync, de, data,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  vsync, hsync, de, data,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/bmp_addr_gen.sv
// Bottom-up BMP address generator: tracks row base, pixel address and x/y
// counters using only add/subtract steps.
module bmp_addr_gen
  import bmp_pkg::*;
#(
  parameter int unsigned HRES      = 320,
  parameter int unsigned VRES      = 240,
  parameter int unsigned HDR_BYTES = BMP_HDR_BYTES,
  parameter int unsigned ADDR_W    = 18
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         load_i,
  input  logic                         next_pix_i,
  input  logic                         next_row_i,
  output logic [ADDR_W-1:0]            pix_addr_o,
  output logic [$clog2(HRES+1)-1:0]    x_o,
  output logic [$clog2(VRES+1)-1:0]    y_o
);

  localparam int unsigned XW     = $clog2(HRES + 1);
  localparam int unsigned YW     = $clog2(VRES + 1);
  localparam int unsigned STRIDE = bmp_stride(HRES);

  // The first line received is the top of the image, stored last in the file.
  localparam logic [ADDR_W-1:0] TopBase = ADDR_W'(HDR_BYTES + (VRES - 1) * STRIDE);
  localparam logic [ADDR_W-1:0] StrideA = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] PixStep = ADDR_W'(BMP_BYTES_PER_PIX);

  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;

  always_comb begin
    row_base_d = row_base_q;
    pix_addr_d = pix_addr_q;
    x_d        = x_q;
    y_d        = y_q;
    if (load_i) begin
      row_base_d = TopBase;
      pix_addr_d = TopBase;
      x_d        = '0;
      y_d        = '0;
    end else if (next_row_i) begin
      row_base_d = row_base_q - StrideA;
      pix_addr_d = row_base_q - StrideA;
      x_d        = '0;
      y_d        = y_q + YW'(1);
    end else if (next_pix_i) begin
      pix_addr_d = pix_addr_q + PixStep;
      x_d        = x_q + XW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_base_q <= '0;
      pix_addr_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      row_base_q <= row_base_d;
      pix_addr_q <= pix_addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign pix_addr_o = pix_addr_q;
  assign x_o        = x_q;
  assign y_o        = y_q;

endmodule

// File: rtl/bmp_capture_ctrl.sv
// Captures one video frame into a BMP-layout byte buffer: bottom-up rows,
// 4-byte padded stride, pixel array after the file header.
module bmp_capture_ctrl
  import bmp_pkg::*;
#(
  parameter int unsigned HRES      = 320,
  parameter int unsigned VRES      = 240,
  parameter int unsigned HDR_BYTES = BMP_HDR_BYTES,
  parameter int unsigned ADDR_W    = 18
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_arm,
  input  logic               i_abort,
  bmp_capture_ctrl_if.slave  vid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int unsigned XW = $clog2(HRES + 1);
  localparam int unsigned YW = $clog2(VRES + 1);
  localparam logic [XW-1:0] XMax = XW'(HRES);
  localparam logic [YW-1:0] YMax = YW'(VRES);

  bmp_state_t        state_q, state_d;
  logic              vsync_q, de_q;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;

  logic              vsync_rise, de_fall;
  logic              ag_load, ag_next_pix, ag_next_row;
  logic [ADDR_W-1:0] pix_addr;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;

  assign vsync_rise = vid.vsync & ~vsync_q;
  assign de_fall    = ~vid.de & de_q;

  bmp_addr_gen #(
    .HRES      (HRES),
    .VRES      (VRES),
    .HDR_BYTES (HDR_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (ag_load),
    .next_pix_i (ag_next_pix),
    .next_row_i (ag_next_row),
    .pix_addr_o (pix_addr),
    .x_o        (x),
    .y_o        (y)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    done_d      = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    ag_load     = 1'b0;
    ag_next_pix = 1'b0;
    ag_next_row = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_arm) begin
          err_d   = 1'b0;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (i_abort) begin
          state_d = StIdle;
        end else if (vsync_rise) begin
          state_d = StCapture;
          ag_load = 1'b1;
        end
      end
      StCapture: begin
        if (i_abort) begin
          state_d = StIdle;
        end else if (vsync_rise) begin
          if (y != YMax || vid.de) err_d = 1'b1;
          state_d = StDone;
          done_d  = ~err_d;
        end else begin
          if (vid.de) begin
            // Lines beyond VRES are never written; they only flag the error.
            if (x < XMax && y < YMax) begin
              wr_en_d     = 1'b1;
              wr_addr_d   = pix_addr;
              wr_data_d   = vid.data;
              ag_next_pix = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            if (vid.hsync) err_d = 1'b1;
          end
          if (de_fall) begin
            if (x != XMax) err_d = 1'b1;
            if (y < YMax) begin
              ag_next_row = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      vsync_q   <= 1'b0;
      de_q      <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      vsync_q   <= vid.vsync;
      de_q      <= vid.de;
      err_q     <= err_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign vid.wr_en   = wr_en_q;
  assign vid.wr_addr = wr_addr_q;
  assign vid.wr_data = wr_data_q;
  assign o_busy      = (state_q == StArmed) || (state_q == StCapture);
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule
